// File: rtl/btn_mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : btn_mmio_pkg
//  Purpose  : Shared types and constants for the memory-mapped pushbutton
//             controller: debounce FSM state type, register word offsets
//             and STATUS register bit positions.
//  Revision : 1.0  initial release
// ============================================================================
package btn_mmio_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED     = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_PRESSED      = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } btn_state_t;

   // Register word offsets from BASE_ADDR
   localparam int STATUS_OFS = 0;
   localparam int COUNT_OFS  = 1;

   // STATUS register bit positions
   localparam int STAT_LEVEL_BIT   = 0;
   localparam int STAT_PRESS_BIT   = 1;
   localparam int STAT_RELEASE_BIT = 2;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop synchroniser for a single asynchronous input bit.
//  Ports    : clk   - destination clock
//             rst_n - asynchronous active-low reset (both flops -> RESET_VAL)
//             i_d   - asynchronous input
//             o_q   - synchronised output (second stage)
//  Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/btn_mmio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : btn_mmio_ctrl
//  Purpose  : Memory-mapped pushbutton controller. Synchronises and debounces
//             an active-low board button, keeps sticky press/release flags
//             and a press counter readable/clearable by software, and emits
//             a one-cycle pulse per accepted press.
//  Ports    : clk         - system clock
//             reset       - asynchronous active-low reset
//             btn_n       - raw pushbutton (0 = pressed), asynchronous
//             adr         - processor data address
//             write_data  - processor store data
//             mem_write   - store strobe
//             mem_read    - load strobe
//             hit         - address selects STATUS or COUNT (combinational)
//             read_data   - register read data, 0 unless hit & mem_read
//             press_pulse - one-cycle pulse per accepted press
//  Revision : 1.0  initial release
// ============================================================================
module btn_mmio_ctrl
   import btn_mmio_pkg::*;
#(
   parameter int                    DATA_WIDTH      = 22,
   parameter int                    ADDR_WIDTH      = 22,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = 22'h3F0,
   parameter int                    DEBOUNCE_CYCLES = 500000,
   parameter int                    CNT_WIDTH       = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  btn_n,
   input  logic [ADDR_WIDTH-1:0] adr,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  mem_write,
   input  logic                  mem_read,
   output logic                  hit,
   output logic [DATA_WIDTH-1:0] read_data,
   output logic                  press_pulse
);

   localparam int DEB_W = $clog2(DEBOUNCE_CYCLES);

   localparam logic [DEB_W-1:0]      c_deb_last    = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] c_status_addr = BASE_ADDR + ADDR_WIDTH'(STATUS_OFS);
   localparam logic [ADDR_WIDTH-1:0] c_count_addr  = BASE_ADDR + ADDR_WIDTH'(COUNT_OFS);

   btn_state_t           r_state;
   logic [DEB_W-1:0]     r_deb_cnt;
   logic                 r_press_flag;
   logic                 r_release_flag;
   logic [CNT_WIDTH-1:0] r_count;
   logic                 r_press_pulse;

   logic w_btn_s;
   logic w_sel_status;
   logic w_sel_count;
   logic w_wr_status;
   logic w_wr_count;
   logic w_level;
   logic w_unused;

   sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_btn_sync (
      .clk   (clk),
      .rst_n (reset),
      .i_d   (btn_n),
      .o_q   (w_btn_s)
   );

   assign w_sel_status = (adr == c_status_addr);
   assign w_sel_count  = (adr == c_count_addr);
   assign hit          = w_sel_status | w_sel_count;
   assign w_wr_status  = mem_write & w_sel_status;
   assign w_wr_count   = mem_write & w_sel_count;
   assign w_level      = (r_state == ST_PRESSED) || (r_state == ST_RELEASE_WAIT);
   assign press_pulse  = r_press_pulse;

   // Only bits [2:1] of a STATUS store carry meaning.
   assign w_unused = ^write_data;

   // Software clears are applied first so that an FSM event on the same
   // edge (assigned later in this block) takes precedence.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= ST_RELEASED;
         r_deb_cnt      <= '0;
         r_press_flag   <= 1'b0;
         r_release_flag <= 1'b0;
         r_count        <= '0;
         r_press_pulse  <= 1'b0;
      end else begin
         r_press_pulse <= 1'b0;

         if (w_wr_status) begin
            if (write_data[STAT_PRESS_BIT])   r_press_flag   <= 1'b0;
            if (write_data[STAT_RELEASE_BIT]) r_release_flag <= 1'b0;
         end
         if (w_wr_count) begin
            r_count <= '0;
         end

         case (r_state)
            ST_RELEASED: begin
               if (!w_btn_s) begin
                  r_state   <= ST_PRESS_WAIT;
                  r_deb_cnt <= '0;
               end
            end
            ST_PRESS_WAIT: begin
               if (w_btn_s) begin
                  r_state <= ST_RELEASED;
               end else if (r_deb_cnt == c_deb_last) begin
                  r_state       <= ST_PRESSED;
                  r_press_pulse <= 1'b1;
                  r_press_flag  <= 1'b1;
                  // A clearing store on this edge still counts this press.
                  r_count       <= w_wr_count ? CNT_WIDTH'(1) : r_count + CNT_WIDTH'(1);
               end else begin
                  r_deb_cnt <= r_deb_cnt + DEB_W'(1);
               end
            end
            ST_PRESSED: begin
               if (w_btn_s) begin
                  r_state   <= ST_RELEASE_WAIT;
                  r_deb_cnt <= '0;
               end
            end
            ST_RELEASE_WAIT: begin
               if (!w_btn_s) begin
                  r_state <= ST_PRESSED;
               end else if (r_deb_cnt == c_deb_last) begin
                  r_state        <= ST_RELEASED;
                  r_release_flag <= 1'b1;
               end else begin
                  r_deb_cnt <= r_deb_cnt + DEB_W'(1);
               end
            end
            default: r_state <= ST_RELEASED;
         endcase
      end
   end

   always_comb begin
      read_data = '0;
      if (mem_read) begin
         if (w_sel_status) begin
            read_data[STAT_LEVEL_BIT]   = w_level;
            read_data[STAT_PRESS_BIT]   = r_press_flag;
            read_data[STAT_RELEASE_BIT] = r_release_flag;
         end else if (w_sel_count) begin
            read_data[CNT_WIDTH-1:0] = r_count;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_btn_mmio_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btn_mmio_ctrl
//  Purpose  : Self-checking bench for btn_mmio_ctrl with a short debounce.
//             A behavioural model tracks how long the synchronised button
//             has disagreed with the accepted level; a level is accepted
//             after DEBOUNCE_CYCLES+1 consecutive disagreeing samples.
//  Revision : 1.0  initial release
// ============================================================================
module tb_btn_mmio_ctrl;

   localparam int          D    = 4;
   localparam int          DW   = 22;
   localparam int          AW   = 22;
   localparam int          CW   = 16;
   localparam logic [21:0] BASE = 22'h3F0;
   localparam logic [21:0] CADR = 22'h3F1;

   logic          clk = 1'b0;
   logic          reset;
   logic          btn_n;
   logic [AW-1:0] adr;
   logic [DW-1:0] write_data;
   logic          mem_write;
   logic          mem_read;
   logic          hit;
   logic [DW-1:0] read_data;
   logic          press_pulse;

   int checks   = 0;
   int failures = 0;

   btn_mmio_ctrl #(
      .DATA_WIDTH      (DW),
      .ADDR_WIDTH      (AW),
      .BASE_ADDR       (BASE),
      .DEBOUNCE_CYCLES (D),
      .CNT_WIDTH       (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn_n       (btn_n),
      .adr         (adr),
      .write_data  (write_data),
      .mem_write   (mem_write),
      .mem_read    (mem_read),
      .hit         (hit),
      .read_data   (read_data),
      .press_pulse (press_pulse)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic        m_s1 = 1'b1, m_s2 = 1'b1;
   logic        m_level = 1'b0;       // 1 = accepted pressed
   int          m_run = 0;            // consecutive samples disagreeing with m_level
   logic        m_pf = 1'b0, m_rf = 1'b0, m_pulse = 1'b0;
   logic [15:0] m_cnt = 16'h0;
   logic        preload_req = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_s1 = 1'b1; m_s2 = 1'b1; m_level = 1'b0; m_run = 0;
         m_pf = 1'b0; m_rf = 1'b0; m_cnt = 16'h0; m_pulse = 1'b0;
      end else begin
         if (preload_req) m_cnt = 16'hFFFF;
         m_pulse = 1'b0;
         if (mem_write && adr == BASE) begin
            if (write_data[1]) m_pf = 1'b0;
            if (write_data[2]) m_rf = 1'b0;
         end
         if (mem_write && adr == CADR) m_cnt = 16'h0;
         if ((!m_s2) != m_level) begin
            m_run = m_run + 1;
            if (m_run == D + 1) begin
               m_level = !m_s2;
               m_run   = 0;
               if (m_level) begin
                  m_pulse = 1'b1;
                  m_pf    = 1'b1;
                  m_cnt   = m_cnt + 16'd1;
               end else begin
                  m_rf = 1'b1;
               end
            end
         end else begin
            m_run = 0;
         end
         m_s2 = m_s1;
         m_s1 = btn_n;
      end
   end

   function automatic logic [21:0] model_rd();
      logic [21:0] v;
      v = '0;
      if (mem_read) begin
         if (adr == BASE)      v = {19'b0, m_rf, m_pf, m_level};
         else if (adr == CADR) v = {6'b0, m_cnt};
      end
      return v;
   endfunction

   task automatic chk(input string name, input logic [21:0] act, input logic [21:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, mid-cycle.
   always @(negedge clk) begin
      chk("model_hit",   {21'b0, hit}, {21'b0, (adr == BASE) || (adr == CADR)});
      chk("model_pulse", {21'b0, press_pulse}, {21'b0, m_pulse});
      chk("model_rdata", read_data, model_rd());
   end

   // ---------------- stimulus helpers ----------------
   task automatic rd(input logic [21:0] a, input logic [21:0] exp, input string name);
      @(posedge clk); #1;
      adr = a; mem_read = 1'b1; mem_write = 1'b0;
      @(negedge clk);
      chk(name, read_data, exp);
   endtask

   task automatic wr(input logic [21:0] a, input logic [21:0] d);
      @(posedge clk); #1;
      adr = a; write_data = d; mem_write = 1'b1; mem_read = 1'b0;
      @(posedge clk); #1;
      mem_write = 1'b0;
   endtask

   task automatic hold_btn(input logic v, input int n);
      @(posedge clk); #1;
      btn_n = v;
      repeat (n) @(posedge clk);
   endtask

   // Press and expect the pulse in the cycle after the 7th edge from the
   // one preceding the btn_n change (2 sync + DEBOUNCE_CYCLES+1 samples).
   task automatic press_check(input string name);
      @(posedge clk); #1;
      btn_n = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk(name, {21'b0, press_pulse}, {21'b0, (i == 7)});
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; btn_n = 1'b1; adr = '0; write_data = '0;
      mem_write = 1'b0; mem_read = 1'b0;
      #12;
      mem_read = 1'b1; adr = BASE;
      #1;
      chk("reset_status", read_data, 22'h0);
      mem_read = 1'b0;
      #10 reset = 1'b1;

      // 1: idle registers
      rd(BASE, 22'h0, "idle_status");
      rd(CADR, 22'h0, "idle_count");

      // 2: clean press
      press_check("press1_pulse");
      rd(BASE, 22'h3, "press1_status");
      rd(CADR, 22'h1, "press1_count");
      chk("press1_hit", {21'b0, hit}, 22'h1);

      // non-hit write ignored
      wr(22'h3F2, 22'h3FFFFF);
      rd(22'h3F2, 22'h0, "nohit_read");
      chk("nohit_hit", {21'b0, hit}, 22'h0);
      rd(BASE, 22'h3, "nohit_status");

      // 4: release, then clear both flags
      hold_btn(1'b1, 12);
      rd(BASE, 22'h6, "release_status");
      wr(BASE, 22'h6);
      rd(BASE, 22'h0, "cleared_status");
      wr(CADR, 22'h155);
      rd(CADR, 22'h0, "count_cleared");

      // 3: bounce rejected
      hold_btn(1'b0, 2);
      @(posedge clk); #1;
      btn_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bounce_pulse", {21'b0, press_pulse}, 22'h0);
      end
      rd(BASE, 22'h0, "bounce_status");
      rd(CADR, 22'h0, "bounce_count");

      // 5a: press_flag clear on acceptance edge -> set wins
      @(posedge clk); #1;
      btn_n = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      adr = BASE; write_data = 22'h2; mem_write = 1'b1; mem_read = 1'b0;
      @(posedge clk); #1;
      mem_write = 1'b0;
      @(negedge clk);
      chk("sim_flag_pulse", {21'b0, press_pulse}, 22'h1);
      rd(BASE, 22'h3, "sim_flag_status");
      rd(CADR, 22'h1, "sim_flag_count");
      hold_btn(1'b1, 12);
      wr(BASE, 22'h6);

      // 5b: COUNT store on acceptance edge -> count = 1
      @(posedge clk); #1;
      btn_n = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      adr = CADR; write_data = 22'h0; mem_write = 1'b1; mem_read = 1'b1;
      @(negedge clk);
      chk("rw_pre_edge", read_data, 22'h1);
      @(posedge clk); #1;
      mem_write = 1'b0;
      rd(CADR, 22'h1, "sim_count");
      hold_btn(1'b1, 12);

      // 6: reset during PRESS_WAIT
      @(posedge clk); #1;
      btn_n = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b0;
      #3 btn_n = 1'b1;
      @(negedge clk);
      chk("mid_reset_pulse", {21'b0, press_pulse}, 22'h0);
      #7 reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("late_pulse", {21'b0, press_pulse}, 22'h0);
      end
      rd(BASE, 22'h0, "post_reset_status");
      rd(CADR, 22'h0, "post_reset_count");

      // wrap: preload counter, press once
      @(posedge clk); #1;
      mem_read = 1'b0;
      force dut.r_count = 16'hFFFF;
      preload_req = 1'b1;
      @(posedge clk); #1;
      release dut.r_count;
      preload_req = 1'b0;
      rd(CADR, 22'h0FFFF, "preload_count");
      press_check("wrap_pulse");
      rd(CADR, 22'h0, "wrap_count");
      hold_btn(1'b1, 12);
      rd(BASE, 22'h6, "wrap_status");

      @(posedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
